pdm_window_counter: RTL

PDM_WINDOW_COUNTER -- requirements
Module: pdm_window_counter

---
 rtl/pdm_window_counter_pkg.sv | 22 ++
 rtl/pdm_window_counter_clk_gen.sv | 39 +++
 rtl/pdm_window_counter.sv | 98 +++++++++
 3 files changed

// File: rtl/pdm_window_counter_pkg.sv
// Shared constants for the PDM microphone front end and its threshold detector.
// Producer and consumer take widths from here so the count bus always lines up.
package pdm_window_counter_pkg;

    localparam int PDM_CLK_DIV    = 25;
    localparam int PDM_WINDOW     = 1000;
    localparam int PDM_CNTR_WIDTH = 10;

    // Threshold detector levels, expressed in ones-per-window.
    localparam int PDM_THRESH_HIGH = 600;
    localparam int PDM_THRESH_LOW  = 400;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } fill_state_e;

    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pdm_window_counter_clk_gen.sv
// Microphone clock divider: mic_clk toggles every CLK_DIV clk cycles, and
// sample_stb marks the clk cycle in which mic_clk falls.
module pdm_clk_gen
    import pdm_window_counter_pkg::*;
#(
    parameter int CLK_DIV = PDM_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic mic_clk,
    output logic sample_stb
);

    localparam int DIV_W = safe_clog2(CLK_DIV);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             mic_clk_q, mic_clk_d;
    logic             div_wrap;

    always_comb begin
        div_wrap  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
        mic_clk_d = div_wrap ? ~mic_clk_q : mic_clk_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            mic_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            mic_clk_q <= mic_clk_d;
        end
    end

    assign mic_clk    = mic_clk_q;
    assign sample_stb = div_wrap & mic_clk_q;

endmodule

// File: rtl/pdm_window_counter.sv
// Sliding-window ones counter for a PDM microphone stream: reports how many of
// the last WINDOW samples were 1, one strobe per sample once the window is full.
module pdm_window_counter
    import pdm_window_counter_pkg::*;
#(
    parameter int CLK_DIV    = PDM_CLK_DIV,
    parameter int WINDOW     = PDM_WINDOW,
    parameter int CNTR_WIDTH = PDM_CNTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mic_data,
    output logic                  mic_clk,
    output logic [CNTR_WIDTH-1:0] cntr,
    output logic                  cntr_valid
);

    localparam int PTR_W = safe_clog2(WINDOW);

    logic                  sample_stb;
    fill_state_e           state_q, state_d;
    logic [WINDOW-1:0]     buf_q, buf_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNTR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
    logic [CNTR_WIDTH-1:0] sum_q, sum_d;
    logic [CNTR_WIDTH-1:0] cntr_q, cntr_d;
    logic                  cntr_valid_q, cntr_valid_d;
    logic                  old_bit;
    logic [CNTR_WIDTH-1:0] new_sum;

    pdm_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .mic_clk   (mic_clk),
        .sample_stb(sample_stb)
    );

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        wr_ptr_d     = wr_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        sum_d        = sum_q;
        cntr_d       = cntr_q;
        cntr_valid_d = 1'b0;

        // The entry under wr_ptr is the sample leaving the window.
        old_bit = buf_q[wr_ptr_q];
        new_sum = sum_q + CNTR_WIDTH'(mic_data) - CNTR_WIDTH'(old_bit);

        if (sample_stb) begin
            buf_d[wr_ptr_q] = mic_data;
            wr_ptr_d        = (wr_ptr_q == PTR_W'(WINDOW - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            sum_d           = new_sum;
            case (state_q)
                ST_FILL: begin
                    fill_cnt_d = fill_cnt_q + CNTR_WIDTH'(1);
                    if (fill_cnt_q == CNTR_WIDTH'(WINDOW - 1)) begin
                        state_d      = ST_RUN;
                        cntr_d       = new_sum;
                        cntr_valid_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    cntr_d       = new_sum;
                    cntr_valid_d = 1'b1;
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FILL;
            buf_q        <= '0;
            wr_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            sum_q        <= '0;
            cntr_q       <= '0;
            cntr_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_cnt_q   <= fill_cnt_d;
            sum_q        <= sum_d;
            cntr_q       <= cntr_d;
            cntr_valid_q <= cntr_valid_d;
        end
    end

    assign cntr       = cntr_q;
    assign cntr_valid = cntr_valid_q;

endmodule
